// File: rtl/proc_fetch_pkg.sv
// Shared definitions for the instruction fetch master and its prefetch queue.
package proc_fetch_pkg;

  // Read latency of the on-chip instruction RAM (address registered, q unregistered).
  localparam int MEM_RD_LATENCY = 1;

  // All byte lanes enabled on every access.
  localparam logic [3:0] BE_ALL = 4'hF;

  // Default geometry of the instruction RAM.
  localparam int FETCH_DATA_W = 32;
  localparam int FETCH_ADDR_W = 8;

  // One prefetched instruction and the word address it came from.
  typedef struct packed {
    logic [FETCH_DATA_W-1:0] data;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/proc_fetch_queue.sv
// Prefetch queue: circular buffer with separate read/write pointers and a count.
// Flush empties the queue and takes priority over a simultaneous push or pop.
module proc_fetch_queue #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage write port.
  // NOTE: storage is not reset; consumers only look at the head while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush) storage[wr_ptr] <= push_data;
  end

  assign head = storage[rd_ptr];

  // The issue rule upstream must keep the queue from ever overflowing or underflowing.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && !flush && count == CNT_W'(DEPTH)));
  a_no_underflow : assert property (@(posedge clk) disable iff (reset)
    !(pop && count == '0));

endmodule

// File: rtl/proc_inst_fetch_master.sv
// Avalon-MM instruction fetch master: owns the fetch PC, issues single-word reads
// to the on-chip instruction RAM and streams returned words to the core through a
// prefetch queue. Branch redirects flush the queue and drop the in-flight read.
// Optional build macro PROC_IFETCH_PERF_EN adds saturating perf_fetched/perf_stall counters.
module proc_inst_fetch_master
  import proc_fetch_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  output logic              mem_reset_req,
  input  logic [DATA_W-1:0] mem_readdata
`ifdef PROC_IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int OCC_W   = CNT_W + 1;
  localparam int ENTRY_W = DATA_W + ADDR_W;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  logic [ADDR_W-1:0]  pc;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_pc;
  logic               pop;
  logic               push;
  logic               issue;
  logic [OCC_W-1:0]   occ_after_pop;
  logic [CNT_W-1:0]   q_count;
  logic [ENTRY_W-1:0] q_head;

  assign pop  = inst_valid & inst_ready;
  // A read returning in a redirect cycle belongs to the abandoned path.
  assign push = inflight & ~redirect_valid;

  // Issue decision: only fetch when the queue plus the outstanding read still leaves room.
  // NOTE: every output of an always_comb gets a value on every path so no latch is inferred.
  always_comb begin
    occ_after_pop = OCC_W'(q_count) + OCC_W'(inflight) - OCC_W'(pop);
    issue         = fetch_en & ~redirect_valid & ~reset & (occ_after_pop < DEPTH_OCC);
  end

  // Fetch PC and the single outstanding read (MEM_RD_LATENCY deep).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= ADDR_W'(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_addr;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + ADDR_W'(1);
        inflight_pc <= pc;
      end
    end
  end

  proc_fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({mem_readdata, inflight_pc}),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (q_count),
    .head      (q_head)
  );

  // Instruction stream; data and pc read as zero whenever the queue is empty.
  assign inst_valid = (q_count != '0);
  assign inst_data  = inst_valid ? q_head[ENTRY_W-1 -: DATA_W] : '0;
  assign inst_pc    = inst_valid ? q_head[ADDR_W-1:0]          : '0;

  // Avalon drive: read-only master, address only meaningful while chipselect is high.
  assign mem_chipselect = issue;
  assign mem_address    = issue ? pc : '0;
  assign mem_write      = 1'b0;
  assign mem_byteenable = BE_ALL;
  assign mem_writedata  = '0;
  assign mem_clken      = 1'b1;
  assign mem_reset_req  = 1'b0;

`ifdef PROC_IFETCH_PERF_EN
  // Saturating counters of delivered instructions and starved fetch cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop && perf_fetched != 32'hFFFF_FFFF) perf_fetched <= perf_fetched + 32'd1;
      if (fetch_en && !inst_valid && perf_stall != 32'hFFFF_FFFF) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_proc_inst_fetch_master.sv
// Self-checking bench for proc_inst_fetch_master: directed literal checks followed by
// randomized traffic against a transaction-level model of the instruction stream.
module tb_proc_inst_fetch_master;
  import proc_fetch_pkg::*;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 2;
  localparam int RESET_PC = 0;

  logic              clk;
  logic              rst;
  logic              fetch_en;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic              mem_reset_req;
  logic [DATA_W-1:0] mem_readdata;
`ifdef PROC_IFETCH_PERF_EN
  logic [31:0]       perf_fetched;
  logic [31:0]       perf_stall;
`endif

  int errors = 0;
  int checks = 0;

  proc_inst_fetch_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_reset_req  (mem_reset_req),
    .mem_readdata   (mem_readdata)
`ifdef PROC_IFETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction RAM model: registered address, unregistered q, word i = A000_0000 + i.
  logic [DATA_W-1:0] mem [256];
  logic [ADDR_W-1:0] rd_addr;
  initial for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
  always @(posedge clk) rd_addr <= mem_address;
  assign mem_readdata = mem[rd_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic to_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level model: the core must see memory words at consecutive PCs
  // starting from RESET_PC or the last redirect target; issued addresses follow
  // the same rule; issued-but-not-consumed reads never exceed DEPTH.
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] exp_pc;
  logic [ADDR_W-1:0] issue_pc;
  int                outstanding;
  int                total_pops;
  logic              prev_hold;
  fetch_entry_t      prev_head;
  int                m_fetched;
  int                m_stall;

  initial total_pops = 0;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst_data", inst_data, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_chipselect", mem_chipselect, 0);
      check("rst_mem_address", mem_address, 0);
      exp_pc      = ADDR_W'(RESET_PC);
      issue_pc    = ADDR_W'(RESET_PC);
      outstanding = 0;
      prev_hold   = 1'b0;
      m_fetched   = 0;
      m_stall     = 0;
    end else begin
      check("tie_write", mem_write, 0);
      check("tie_byteenable", mem_byteenable, 4'hF);
      check("tie_ctrl", {mem_clken, mem_reset_req, mem_writedata}, {1'b1, 1'b0, 32'h0});
      if (redirect_valid || !fetch_en) check("no_issue", mem_chipselect, 0);
      if (mem_chipselect) check("issue_addr", mem_address, issue_pc);
      if (prev_hold) begin
        check("hold_valid", inst_valid, 1);
        check("hold_entry", {inst_data, inst_pc}, prev_head);
      end
      if (inst_valid) check("data_of_pc", inst_data, mem[inst_pc]);
`ifdef PROC_IFETCH_PERF_EN
      check("perf_fetched", perf_fetched, m_fetched);
      check("perf_stall", perf_stall, m_stall);
      if (fetch_en && !inst_valid) m_stall++;
`endif
      if (inst_valid && inst_ready) begin
        check("pop_pc", inst_pc, exp_pc);
        check("pop_data", inst_data, mem[exp_pc]);
        exp_pc = exp_pc + 1'b1;
        total_pops++;
        m_fetched++;
      end
      if (redirect_valid) begin
        exp_pc      = redirect_addr;
        issue_pc    = redirect_addr;
        outstanding = 0;
      end else begin
        if (mem_chipselect) begin
          issue_pc = issue_pc + 1'b1;
          outstanding++;
        end
        if (inst_valid && inst_ready) outstanding--;
      end
      check("occupancy", outstanding <= DEPTH, 1);
      prev_hold      = inst_valid & ~inst_ready & ~redirect_valid;
      prev_head.data = inst_data;
      prev_head.pc   = inst_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed scenarios with hand-computed expectations, then random traffic.
  // ---------------------------------------------------------------------------
  initial begin
    int           n_cs;
    int           found;
    int           wait_cyc;
    int           got;
    logic [7:0]   seq [4];
    logic [7:0]   want [4];

    rst = 1'b1; fetch_en = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_addr = '0;

    // Reset, then straight-line streaming from RESET_PC.
    to_cycle(); fetch_en = 1'b1; inst_ready = 1'b1;
    to_cycle(); rst = 1'b0;                       // cycle 1
    @(negedge clk);
    check("c1_chipselect", mem_chipselect, 1);
    check("c1_address", mem_address, 8'h00);
    check("c1_valid", inst_valid, 0);
    to_cycle(); @(negedge clk);                   // cycle 2
    check("c2_valid", inst_valid, 0);
    to_cycle(); @(negedge clk);                   // cycle 3
    check("c3_valid", inst_valid, 1);
    check("c3_pc", inst_pc, 8'h00);
    check("c3_data", inst_data, 32'hA000_0000);
    for (int k = 1; k < 8; k++) begin
      to_cycle(); @(negedge clk);
      check("stream_valid", inst_valid, 1);
      check("stream_pc", inst_pc, k);
    end

    // Back-pressure: core not ready for 12 cycles.
    to_cycle(); rst = 1'b1; inst_ready = 1'b0;
    to_cycle(); rst = 1'b0;                       // cycle 1
    n_cs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cs += int'(mem_chipselect);
      if (i >= 2) check("stall_data", inst_data, 32'hA000_0000);
      to_cycle();
    end
    check("stall_issue_count", n_cs, DEPTH);
    inst_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("drain_valid", inst_valid, 1);
      check("drain_pc", inst_pc, k);
      to_cycle();
    end

    // Redirect to 0x40 while the read of word 5 is in flight (cycle 7).
    rst = 1'b1;
    to_cycle(); rst = 1'b0;                       // cycle 1
    repeat (6) to_cycle();                        // cycle 7
    redirect_valid = 1'b1; redirect_addr = 8'h40;
    @(negedge clk);
    check("redir_head_pc", inst_pc, 8'h04);
    to_cycle(); redirect_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      @(negedge clk);
      if (inst_valid) found = 1;
      else to_cycle();
    end
    check("redir_found", found, 1);
    check("redir_pc", inst_pc, 8'h40);
    check("redir_data", inst_data, 32'hA000_0040);

    // Address wrap from 0xFE.
    to_cycle(); redirect_valid = 1'b1; redirect_addr = 8'hFE;
    to_cycle(); redirect_valid = 1'b0;
    want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00; want[3] = 8'h01;
    got = 0;
    for (int i = 0; i < 20 && got < 4; i++) begin
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        seq[got] = inst_pc;
        got++;
      end
      to_cycle();
    end
    check("wrap_count", got, 4);
    for (int i = 0; i < 4; i++) if (i < got) check("wrap_pc", seq[i], want[i]);

    // One-cycle reset during streaming.
    rst = 1'b1;
    #1;
    check("async_rst_valid", inst_valid, 0);
    check("async_rst_cs", mem_chipselect, 0);
    to_cycle(); rst = 1'b0;                       // cycle 1
    wait_cyc = 0; found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      @(negedge clk);
      if (inst_valid) found = 1;
      else begin wait_cyc++; to_cycle(); end
    end
    check("restart_found", found, 1);
    check("restart_latency", wait_cyc, 2);
    check("restart_pc", inst_pc, RESET_PC);

    // Randomized traffic; the model process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      to_cycle();
      if (rst) rst = 1'b0;
      else if ($urandom_range(399) == 0) rst = 1'b1;
      fetch_en       = ($urandom_range(9) < 8);
      inst_ready     = ($urandom_range(9) < 7);
      redirect_valid = ($urandom_range(19) == 0);
      redirect_addr  = 8'($urandom);
    end
    to_cycle(); rst = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    check("random_progress", total_pops > 500, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
